// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matmul engine between two requesters.
// Captures the winner's operands, starts the engine and waits for done or a timeout.
module matmul_arbiter #(
    parameter int unsigned S   = 32,
    parameter int unsigned H   = 2,
    parameter int unsigned W   = 2,
    parameter int unsigned C   = 3,
    parameter int unsigned TMO = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [H*C*S-1:0]   a0,
    input  logic [H*C*S-1:0]   a1,
    input  logic [C*W*S-1:0]   b0,
    input  logic [C*W*S-1:0]   b1,
    output logic [1:0]         ack,
    output logic               err,
    output logic [H*W*S-1:0]   res,
    output logic               busy,
    output logic               mm_start,
    output logic [H*C*S-1:0]   mm_a,
    output logic [C*W*S-1:0]   mm_b,
    input  logic [H*W*S-1:0]   mm_o,
    input  logic               mm_done
);

    localparam logic [15:0] TmoCnt = 16'(TMO);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [H*W*S-1:0]   res_q, res_d;
    logic [H*C*S-1:0]   mm_a_q, mm_a_d;
    logic [C*W*S-1:0]   mm_b_q, mm_b_d;
    logic               grant_sel;
    logic               done_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            mm_a_q  <= '0;
            mm_b_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            mm_a_q  <= mm_a_d;
            mm_b_q  <= mm_b_d;
        end
    end

    // On a tie the requester not served last wins; a lone request wins outright.
    assign grant_sel = (req == 2'b11) ? ~last_q : req[1];
    // Only a fresh 0->1 transition completes a job, never a stale high level.
    assign done_edge = mm_done & ~done_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        err_d   = err_q;
        done_d  = mm_done;
        cnt_d   = cnt_q;
        res_d   = res_q;
        mm_a_d  = mm_a_q;
        mm_b_d  = mm_b_q;
        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    grant_d = grant_sel;
                    last_d  = grant_sel;
                    mm_a_d  = grant_sel ? a1 : a0;
                    mm_b_d  = grant_sel ? b1 : b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_edge) begin
                    res_d   = mm_o;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == TmoCnt) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ack = 2'b00;
        if (state_q == StResp) begin
            ack = grant_q ? 2'b10 : 2'b01;
        end
    end

    assign err      = (state_q == StResp) & err_q;
    assign res      = res_q;
    assign busy     = (state_q != StIdle);
    assign mm_start = (state_q == StIssue);
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter: arbitration order, latency, timeout, reset abort,
// stale done level and operand capture.
module tb_matmul_arbiter;

    localparam int AW = 2 * 3 * 32;
    localparam int BW = 3 * 2 * 32;
    localparam int OW = 2 * 2 * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] b0, b1;
    logic [1:0]    ack;
    logic          err;
    logic [OW-1:0] res;
    logic          busy;
    logic          mm_start;
    logic [AW-1:0] mm_a;
    logic [BW-1:0] mm_b;
    logic [OW-1:0] mm_o;
    logic          mm_done;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    logic both_ack = 1'b0;

    matmul_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1),
        .ack      (ack),
        .err      (err),
        .res      (res),
        .busy     (busy),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_o     (mm_o),
        .mm_done  (mm_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack != 2'b00) ack_cnt = ack_cnt + 1;
        if (ack == 2'b11) both_ack = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        mm_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Starts from IDLE with req already driven; ends one cycle after the ack, back in IDLE.
    task automatic run_job(input string tag, input logic [AW-1:0] exp_a, input logic [1:0] exp_ack,
                           input logic [OW-1:0] o, input logic chg_a0);
        step();
        check_eq({tag, "_start"}, 256'(mm_start), 256'(1));
        check_eq({tag, "_mma"}, 256'(mm_a), 256'(exp_a));
        if (chg_a0) a0 = ~a0;
        mm_done = 1'b0;
        mm_o = o;
        repeat (9) step();
        check_eq({tag, "_noack"}, 256'(ack), 256'(0));
        mm_done = 1'b1;
        step();
        check_eq({tag, "_ack"}, 256'(ack), 256'(exp_ack));
        check_eq({tag, "_err"}, 256'(err), 256'(0));
        check_eq({tag, "_res"}, 256'(res), 256'(o));
        check_eq({tag, "_mma_hold"}, 256'(mm_a), 256'(exp_a));
        step();
        check_eq({tag, "_ack_end"}, 256'(ack), 256'(0));
    endtask

    logic [AW-1:0] pa0, pa1;
    logic [BW-1:0] pb0;
    logic [OW-1:0] ones, p2, p3;

    initial begin
        int n;
        int c0;
        pa0  = {32'h3f800000, 32'h40000000, 32'h40400000,
                32'h40800000, 32'h40a00000, 32'h40c00000};
        pa1  = {6{32'h41200000}};
        pb0  = {32'h40c00000, 32'h40a00000, 32'h40800000,
                32'h40400000, 32'h40000000, 32'h3f800000};
        ones = {4{32'h3f800000}};
        p2   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        p3   = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        a0 = pa0; a1 = pa1; b0 = pb0; b1 = '0; mm_o = '0;
        do_reset();

        check_eq("rst_busy", 256'(busy), 256'(0));
        check_eq("rst_ack", 256'(ack), 256'(0));
        check_eq("rst_res", 256'(res), 256'(0));
        check_eq("rst_mma", 256'(mm_a), 256'(0));
        check_eq("rst_start", 256'(mm_start), 256'(0));

        // Single request, 10-cycle engine
        req = 2'b01;
        run_job("single", pa0, 2'b01, ones, 1'b0);
        check_eq("single_mmb", 256'(mm_b), 256'(pb0));
        req = 2'b00;

        // Timeout: engine never answers, res keeps the previous result
        mm_done = 1'b0;
        req = 2'b10;
        step();
        check_eq("tmo_start", 256'(mm_start), 256'(1));
        check_eq("tmo_mma", 256'(mm_a), 256'(pa1));
        n = 0;
        while (ack == 2'b00 && n < 300) begin
            step();
            n++;
        end
        check_eq("tmo_lat", 256'(n >= 256 && n <= 257), 256'(1));
        check_eq("tmo_ack", 256'(ack), 256'(2'b10));
        check_eq("tmo_err", 256'(err), 256'(1));
        check_eq("tmo_res", 256'(res), 256'(ones));
        req = 2'b00;
        step();

        // Round robin with both held
        do_reset();
        a0 = pa0; a1 = pa1;
        req = 2'b11;
        run_job("rr0", pa0, 2'b01, p2, 1'b0);
        run_job("rr1", pa1, 2'b10, p3, 1'b0);
        run_job("rr2", pa0, 2'b01, ones, 1'b0);
        req = 2'b00;
        check_eq("rr_exclusive", 256'(both_ack), 256'(0));

        // Operand capture, then stale done level from that job
        do_reset();
        a0 = pa0;
        req = 2'b01;
        run_job("capt", pa0, 2'b01, p2, 1'b1);
        a0 = pa0;
        step();
        check_eq("stale_start", 256'(mm_start), 256'(1));
        req = 2'b00;
        mm_o = p3;
        c0 = ack_cnt;
        repeat (20) step();
        check_eq("stale_noack", 256'(ack_cnt - c0), 256'(0));
        check_eq("stale_busy", 256'(busy), 256'(1));
        mm_done = 1'b0;
        step();
        mm_done = 1'b1;
        step();
        check_eq("stale_ack", 256'(ack), 256'(2'b01));
        check_eq("stale_res", 256'(res), 256'(p3));
        check_eq("stale_err", 256'(err), 256'(0));
        step();

        // Reset mid-WAIT aborts the job
        do_reset();
        req = 2'b01;
        step();
        mm_done = 1'b0;
        repeat (3) step();
        check_eq("abort_inwait", 256'({busy, mm_start}), 256'(2'b10));
        req = 2'b00;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 256'(busy), 256'(0));
        check_eq("abort_ack_err", 256'({ack, err, mm_start}), 256'(0));
        check_eq("abort_res", 256'(res), 256'(0));
        check_eq("abort_mma", 256'(mm_a), 256'(0));
        check_eq("abort_mmb", 256'(mm_b), 256'(0));
        #2;
        rst = 1'b0;
        c0 = ack_cnt;
        step();
        mm_done = 1'b1;
        repeat (20) step();
        check_eq("abort_noack", 256'(ack_cnt - c0), 256'(0));
        check_eq("abort_idle", 256'(busy), 256'(0));
        check_eq("never_both", 256'(both_ack), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
